// File: rtl/echo_fb_multi.sv
// Mono echo / feedback-delay unit with circular delay buffer.
// Programmable delay, fractional gain, saturating mix, fixed 2-cycle latency.
module echo_fb_multi #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int GAIN_WIDTH = 6,
  parameter int MIN_DELAY  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] audio_in,
  input  logic [ADDR_WIDTH-1:0] delay_num,
  input  logic [GAIN_WIDTH-1:0] gain,
  input  logic                  fb_en,
  input  logic                  bypass,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] echo_data,
  output logic                  sat_flag,
  output logic                  primed
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int GW    = GAIN_WIDTH;
  localparam int PW    = DW + GW + 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW-1:0] MIN_D    = AW'(MIN_DELAY);
  localparam logic [AW-1:0] FILL_MAX = '1;
  localparam logic [DW-1:0] Y_MAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Y_MIN    = {1'b1, {(DW-1){1'b0}}};

  // S0 bookkeeping
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [AW-1:0] dly_q, dly_d;
  logic [AW-1:0] d_eff;
  logic [AW-1:0] rd_addr;
  logic          d_chg;

  // sample carried from S0 into the mix stage
  logic          v1_q, v1_d;
  logic [DW-1:0] x1_q, x1_d;
  logic [AW-1:0] wa1_q, wa1_d;
  logic [GW-1:0] g1_q, g1_d;
  logic          fb1_q, fb1_d;
  logic          byp1_q, byp1_d;
  logic          pr1_q, pr1_d;

  // mix stage
  logic [DW-1:0]        ram_rd_q;
  logic [DW-1:0]        d_sel;
  logic [PW-1:0]        d_ext;
  logic [PW-1:0]        g_ext;
  logic signed [PW-1:0] prod;
  logic [DW-1:0]        p;
  logic [DW:0]          s;
  logic                 ovf;
  logic [DW-1:0]        y;
  logic [DW-1:0]        wr_data;

  // output registers
  logic          ov_q, ov_d;
  logic [DW-1:0] echo_q, echo_d;
  logic          sat_q, sat_d;

  logic [DW-1:0] mem [DEPTH];

  // S0: clamp delay, form read address, advance pointer and fill count
  always_comb begin
    d_eff    = (delay_num < MIN_D) ? MIN_D : delay_num;
    d_chg    = (d_eff != dly_q);
    rd_addr  = wr_ptr_q - d_eff;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    dly_d    = dly_q;
    v1_d     = in_valid;
    x1_d     = x1_q;
    wa1_d    = wa1_q;
    g1_d     = g1_q;
    fb1_d    = fb1_q;
    byp1_d   = byp1_q;
    pr1_d    = pr1_q;
    if (in_valid) begin
      dly_d    = d_eff;
      wr_ptr_d = wr_ptr_q + 1'b1;
      x1_d     = audio_in;
      wa1_d    = wr_ptr_q;
      g1_d     = gain;
      fb1_d    = fb_en;
      byp1_d   = bypass;
      // a delay change restarts the count with this sample
      pr1_d    = !d_chg && (fill_q >= d_eff);
      if (d_chg) begin
        fill_d = AW'(1);
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // mix: scale masked tap, add dry sample, clamp, pick output
  always_comb begin
    d_sel   = pr1_q ? ram_rd_q : '0;
    d_ext   = {{(GW+1){d_sel[DW-1]}}, d_sel};
    g_ext   = {{(DW+1){1'b0}}, g1_q};
    prod    = $signed(d_ext) * $signed(g_ext);
    p       = DW'(prod >>> GW);
    s       = {x1_q[DW-1], x1_q} + {p[DW-1], p};
    ovf     = s[DW] ^ s[DW-1];
    y       = ovf ? (s[DW] ? Y_MIN : Y_MAX)
                  : s[DW-1:0];
    wr_data = fb1_q ? y : x1_q;
    ov_d    = v1_q;
    echo_d  = echo_q;
    sat_d   = sat_q;
    if (v1_q) begin
      echo_d = byp1_q ? x1_q : y;
      sat_d  = ovf;
    end
  end

  // delay buffer: read in S0, write back from the mix stage
  always_ff @(posedge clk) begin
    if (in_valid) ram_rd_q <= mem[rd_addr];
    if (v1_q) mem[wa1_q] <= wr_data;
  end

  // control and pipeline registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      dly_q    <= MIN_D;
      v1_q     <= 1'b0;
      x1_q     <= '0;
      wa1_q    <= '0;
      g1_q     <= '0;
      fb1_q    <= 1'b0;
      byp1_q   <= 1'b0;
      pr1_q    <= 1'b0;
      ov_q     <= 1'b0;
      echo_q   <= '0;
      sat_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      dly_q    <= dly_d;
      v1_q     <= v1_d;
      x1_q     <= x1_d;
      wa1_q    <= wa1_d;
      g1_q     <= g1_d;
      fb1_q    <= fb1_d;
      byp1_q   <= byp1_d;
      pr1_q    <= pr1_d;
      ov_q     <= ov_d;
      echo_q   <= echo_d;
      sat_q    <= sat_d;
    end
  end

  assign out_valid = ov_q;
  assign echo_data = echo_q;
  assign sat_flag  = sat_q;
  assign primed    = (fill_q >= dly_q);

endmodule

// File: tb/tb_echo_fb_multi.sv
// Bench for echo_fb_multi: reference model feeds a scoreboard queue,
// a negedge monitor pops and compares each out_valid sample.
module tb_echo_fb_multi;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] audio_in;
  logic [11:0] delay_num;
  logic [5:0]  gain;
  logic        fb_en;
  logic        bypass;
  logic        out_valid;
  logic [15:0] echo_data;
  logic        sat_flag;
  logic        primed;

  echo_fb_multi dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .audio_in  (audio_in),
    .delay_num (delay_num),
    .gain      (gain),
    .fb_en     (fb_en),
    .bypass    (bypass),
    .out_valid (out_valid),
    .echo_data (echo_data),
    .sat_flag  (sat_flag),
    .primed    (primed)
  );

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [15:0] got[$];
  logic        got_sat[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;

  int m_wp, m_fill, m_dly;
  int mem_m [4096];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sbq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL stray_out_valid got=1 exp=0 cyc=%0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        nvec++;
        if (echo_data !== mon_e.data) begin
          nerr++;
          $display("FAIL echo_data got=%0d exp=%0d cyc=%0d",
                   $signed(echo_data), $signed(mon_e.data), cyc);
        end
        nvec++;
        if (sat_flag !== mon_e.sat) begin
          nerr++;
          $display("FAIL sat_flag got=%0b exp=%0b cyc=%0d",
                   sat_flag, mon_e.sat, cyc);
        end
        nvec++;
        if (cyc !== mon_e.cyc) begin
          nerr++;
          $display("FAIL latency got_cyc=%0d exp_cyc=%0d", cyc, mon_e.cyc);
        end
        got.push_back(echo_data);
        got_sat.push_back(sat_flag);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_wp   = 0;
    m_fill = 0;
    m_dly  = 4;
  endtask

  task automatic model_step(input int x, input int dn, input int g,
                            input bit fb, input bit byp,
                            output int e, output bit sat);
    int dd, d, p, s, y;
    bit pr, chg;
    dd  = (dn < 4) ? 4 : dn;
    chg = (dd != m_dly);
    pr  = !chg && (m_fill >= dd);
    if (chg) m_fill = 1;
    else if (m_fill < 4095) m_fill = m_fill + 1;
    m_dly = dd;
    d = pr ? mem_m[(m_wp - dd) & 4095] : 0;
    p = (d * g) >>> 6;
    s = x + p;
    y = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    sat = (s != y);
    e = byp ? x : y;
    mem_m[m_wp] = fb ? y : x;
    m_wp = (m_wp + 1) % 4096;
  endtask

  task automatic send(input int x, input int dn, input int g,
                      input bit fb, input bit byp);
    int e;
    bit st;
    in_valid  = 1'b1;
    audio_in  = 16'(x);
    delay_num = 12'(dn);
    gain      = 6'(g);
    fb_en     = fb;
    bypass    = byp;
    model_step(x, dn, g, fb, byp, e, st);
    sbq.push_back('{16'(e), st, cyc + 2});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset_n  = 1'b0;
    sbq.delete();
    got.delete();
    got_sat.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL rst_out_valid got=%0b exp=0", out_valid);
    end
    nvec++;
    if (echo_data !== 16'd0) begin
      nerr++;
      $display("FAIL rst_echo_data got=%0d exp=0", echo_data);
    end
    nvec++;
    if (sat_flag !== 1'b0) begin
      nerr++;
      $display("FAIL rst_sat_flag got=%0b exp=0", sat_flag);
    end
    nvec++;
    if (primed !== 1'b0) begin
      nerr++;
      $display("FAIL rst_primed got=%0b exp=0", primed);
    end
    do_reset();
    nvec++;
    if (primed !== 1'b0) begin
      nerr++;
      $display("FAIL post_rst_primed got=%0b exp=0", primed);
    end
  endtask

  task automatic test_impulse(input bit fb);
    int ev;
    do_reset();
    send(1000, 8, 32, fb, 1'b0);
    for (int i = 1; i < 40; i++) send(0, 8, 32, fb, 1'b0);
    idle(4);
    nvec++;
    if (sbq.size() != 0 || got.size() != 40) begin
      nerr++;
      $display("FAIL impulse_drain got=%0d exp=40", got.size());
    end
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      ev = 0;
      if (i == 0) ev = 1000;
      else if (i == 8) ev = 500;
      else if (fb && i == 16) ev = 250;
      else if (fb && i == 24) ev = 125;
      else if (fb && i == 32) ev = 62;
      nvec++;
      if (got[i] !== 16'(ev)) begin
        nerr++;
        $display("FAIL impulse_fb%0b[%0d] got=%0d exp=%0d",
                 fb, i, $signed(got[i]), ev);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 12; i++) send(30000, 4, 63, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) send(-30000, 4, 63, 1'b0, 1'b0);
    idle(4);
    nvec++;
    if (got.size() != 24) begin
      nerr++;
      $display("FAIL sat_drain got=%0d exp=24", got.size());
    end else begin
      nvec++;
      if (got[11] !== 16'h7fff || got_sat[11] !== 1'b1) begin
        nerr++;
        $display("FAIL sat_pos got=%0d/%0b exp=32767/1",
                 $signed(got[11]), got_sat[11]);
      end
      nvec++;
      if (got[23] !== 16'h8000 || got_sat[23] !== 1'b1) begin
        nerr++;
        $display("FAIL sat_neg got=%0d/%0b exp=-32768/1",
                 $signed(got[23]), got_sat[23]);
      end
      nvec++;
      if (got[0] !== 16'd30000 || got_sat[0] !== 1'b0) begin
        nerr++;
        $display("FAIL sat_unprimed got=%0d/%0b exp=30000/0",
                 $signed(got[0]), got_sat[0]);
      end
    end
  endtask

  task automatic test_delay();
    do_reset();
    send(1000, 1, 32, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) send(0, 1, 32, 1'b0, 1'b0);
    idle(4);
    nvec++;
    if (got.size() != 10 || got[4] !== 16'd500 || got[3] !== 16'd0) begin
      nerr++;
      $display("FAIL min_delay got=%0d exp=500", (got.size() > 4) ? got[4] : 0);
    end
    do_reset();
    for (int i = 0; i < 20; i++) send(100, 8, 32, 1'b0, 1'b0);
    nvec++;
    if (primed !== 1'b1) begin
      nerr++;
      $display("FAIL primed_d8 got=%0b exp=1", primed);
    end
    send(100, 16, 32, 1'b0, 1'b0);
    nvec++;
    if (primed !== 1'b0) begin
      nerr++;
      $display("FAIL primed_drop got=%0b exp=0", primed);
    end
    for (int i = 1; i < 24; i++) send(100, 16, 32, 1'b0, 1'b0);
    nvec++;
    if (primed !== 1'b1) begin
      nerr++;
      $display("FAIL primed_d16 got=%0b exp=1", primed);
    end
    idle(4);
    nvec++;
    if (got.size() != 44) begin
      nerr++;
      $display("FAIL delay_drain got=%0d exp=44", got.size());
    end else begin
      for (int i = 20; i < 44; i++) begin
        nvec++;
        if (got[i] !== ((i < 36) ? 16'd100 : 16'd150)) begin
          nerr++;
          $display("FAIL mute[%0d] got=%0d exp=%0d",
                   i, got[i], (i < 36) ? 100 : 150);
        end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 9000; i++)
      send(int'($urandom_range(0, 65535)) - 32768, 4095,
           int'($urandom_range(0, 63)), 1'b1, 1'b0);
    idle(4);
    nvec++;
    if (sbq.size() != 0 || got.size() != 9000) begin
      nerr++;
      $display("FAIL wrap_drain got=%0d exp=9000", got.size());
    end
  endtask

  task automatic test_bypass();
    int xs[$];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      xs.push_back(int'($urandom_range(0, 40000)) - 20000);
      send(xs[i], 4, 32, 1'b1, 1'b1);
    end
    idle(4);
    nvec++;
    if (got.size() != 20) begin
      nerr++;
      $display("FAIL bypass_drain got=%0d exp=20", got.size());
    end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      nvec++;
      if (got[i] !== 16'(xs[i])) begin
        nerr++;
        $display("FAIL bypass[%0d] got=%0d exp=%0d",
                 i, $signed(got[i]), xs[i]);
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    for (int i = 0; i < 6; i++) send(1000 + i, 4, 32, 1'b0, 1'b0);
    reset_n = 1'b0;
    sbq.delete();
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0 || echo_data !== 16'd0 || sat_flag !== 1'b0) begin
        nerr++;
        $display("FAIL midrst_out got=%0b/%0d/%0b exp=0/0/0",
                 out_valid, echo_data, sat_flag);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    got.delete();
    got_sat.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL midrst_stray got=%0b exp=0", out_valid);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) send(200 * i, 4, 48, 1'b1, 1'b0);
    idle(4);
    nvec++;
    if (sbq.size() != 0 || got.size() != 10) begin
      nerr++;
      $display("FAIL midrst_resume got=%0d exp=10", got.size());
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    audio_in  = '0;
    delay_num = '0;
    gain      = '0;
    fb_en     = 1'b0;
    bypass    = 1'b0;
    model_reset();
    test_reset();
    test_impulse(1'b0);
    test_impulse(1'b1);
    test_saturation();
    test_delay();
    test_wrap();
    test_bypass();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
